decode_stage: RTL and testbench

- Instruction decode stage of the 5-stage core.
- Consumes the IF/ID pair (if_id_nextpc, if_id_instruc) from fetch, reads the register bank, and resolves branches and jumps in ID.
- Drives the PC-redirect interface back to fetch (id_if_*), which fetch samples on its next rising clock edge.
- Registers decoded control and operands into the ID/EX pipeline register; squashes the one wrong-path instruction after a redirect.

---
 rtl/decode_if.sv | 53 +++++
 rtl/decode_stage.sv | 175 +++++++++++++++++
 tb/tb_decode_stage.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_if.sv
// ID-stage bus bundle: fetch handoff (if_id_*), PC redirect (id_if_*), register bank
// read ports (id_reg_*/reg_id_*), writeback bypass source (wb_id_*), execute stall and
// the ID/EX pipeline register outputs (id_ex_*).
//   master : the decode stage (drives id_if_*, id_reg_*, id_ex_*)
//   slave  : the surrounding pipeline / register bank
interface decode_if;
    logic        ex_if_stall;
    logic [31:0] if_id_nextpc;
    logic [31:0] if_id_instruc;
    logic        id_if_selpcsource;
    logic [1:0]  id_if_selpctype;
    logic [31:0] id_if_pcimd2ext;
    logic [31:0] id_if_rega;
    logic [31:0] id_if_pcindex;
    logic [4:0]  id_reg_addra;
    logic [4:0]  id_reg_addrb;
    logic [31:0] reg_id_dataa;
    logic [31:0] reg_id_datab;
    logic        wb_id_writereg;
    logic [4:0]  wb_id_regdest;
    logic [31:0] wb_id_writedata;
    logic [31:0] id_ex_instruc;
    logic [31:0] id_ex_nextpc;
    logic [31:0] id_ex_rega;
    logic [31:0] id_ex_regb;
    logic [31:0] id_ex_imedext;
    logic [4:0]  id_ex_regdest;
    logic        id_ex_writereg;
    logic        id_ex_memread;
    logic        id_ex_memwrite;
    logic        id_ex_alusrc;
    logic [3:0]  id_ex_aluop;

    modport master (
        input  ex_if_stall, if_id_nextpc, if_id_instruc, reg_id_dataa, reg_id_datab,
               wb_id_writereg, wb_id_regdest, wb_id_writedata,
        output id_if_selpcsource, id_if_selpctype, id_if_pcimd2ext, id_if_rega, id_if_pcindex,
               id_reg_addra, id_reg_addrb,
               id_ex_instruc, id_ex_nextpc, id_ex_rega, id_ex_regb, id_ex_imedext,
               id_ex_regdest, id_ex_writereg, id_ex_memread, id_ex_memwrite, id_ex_alusrc,
               id_ex_aluop
    );

    modport slave (
        output ex_if_stall, if_id_nextpc, if_id_instruc, reg_id_dataa, reg_id_datab,
               wb_id_writereg, wb_id_regdest, wb_id_writedata,
        input  id_if_selpcsource, id_if_selpctype, id_if_pcimd2ext, id_if_rega, id_if_pcindex,
               id_reg_addra, id_reg_addrb,
               id_ex_instruc, id_ex_nextpc, id_ex_rega, id_ex_regb, id_ex_imedext,
               id_ex_regdest, id_ex_writereg, id_ex_memread, id_ex_memwrite, id_ex_alusrc,
               id_ex_aluop
    );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: decodes the IF/ID instruction, reads register operands,
// resolves branches/jumps (combinational redirect to fetch) and registers the decoded
// control/operands into ID/EX. One wrong-path instruction is squashed after a redirect.
// Ports: clock, reset (async, active-high), bus (decode_if.master).
// Optional: define ID_WB_BYPASS_EN to forward the WB write data onto rs/rt operands.
module decode_stage #(
    parameter logic [31:0] VECTOR_ADDR = 32'h0000_0040
) (
    input logic      clock,
    input logic      reset,
    decode_if.master bus
);
    typedef enum logic [0:0] {RUN = 1'b0, SQUASH = 1'b1} state_e;

    typedef struct packed {
        logic [31:0] instruc;
        logic [31:0] nextpc;
        logic [31:0] rega;
        logic [31:0] regb;
        logic [31:0] imedext;
        logic [4:0]  regdest;
        logic        writereg;
        logic        memread;
        logic        memwrite;
        logic        alusrc;
        logic [3:0]  aluop;
    } idex_t;

    state_e state_q, state_d;
    idex_t  idex_q, idex_d, dec_c;

    logic [31:0] instr, nextpc, opa, opb, sext_imm, br_target, jmp_target;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic        illegal, is_beq, is_bne, is_jr, is_j, writer, take_c;
    logic [1:0]  type_c;

    assign instr  = bus.if_id_instruc;
    assign nextpc = bus.if_id_nextpc;
    assign op     = instr[31:26];
    assign funct  = instr[5:0];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];

    assign bus.id_reg_addra = rs;
    assign bus.id_reg_addrb = rt;

    // Source operands, optionally forwarded from the writeback port
`ifdef ID_WB_BYPASS_EN
    assign opa = (bus.wb_id_writereg && (bus.wb_id_regdest != 5'd0) && (bus.wb_id_regdest == rs))
               ? bus.wb_id_writedata : bus.reg_id_dataa;
    assign opb = (bus.wb_id_writereg && (bus.wb_id_regdest != 5'd0) && (bus.wb_id_regdest == rt))
               ? bus.wb_id_writedata : bus.reg_id_datab;
`else
    logic unused_wb;
    assign unused_wb = ^{bus.wb_id_writereg, bus.wb_id_regdest, bus.wb_id_writedata};
    assign opa = bus.reg_id_dataa;
    assign opb = bus.reg_id_datab;
`endif

    assign sext_imm   = {{16{instr[15]}}, instr[15:0]};
    assign br_target  = nextpc + {sext_imm[29:0], 2'b00};
    assign jmp_target = {nextpc[31:28], instr[25:0], 2'b00};

    // Instruction decode; the all-zero nop falls through with every control bit clear
    always_comb begin
        illegal = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_jr   = 1'b0;
        is_j    = 1'b0;
        writer  = 1'b0;
        dec_c   = '0;
        dec_c.instruc = instr;
        dec_c.nextpc  = nextpc;
        dec_c.rega    = opa;
        dec_c.regb    = opb;
        dec_c.imedext = sext_imm;
        if (instr != 32'd0) begin
            case (op)
                6'b000000: begin
                    writer        = 1'b1;
                    dec_c.regdest = rd;
                    case (funct)
                        6'b100000: dec_c.aluop = 4'd0;
                        6'b100010: dec_c.aluop = 4'd1;
                        6'b100100: dec_c.aluop = 4'd2;
                        6'b100101: dec_c.aluop = 4'd3;
                        6'b101010: dec_c.aluop = 4'd4;
                        6'b001000: begin is_jr = 1'b1; writer = 1'b0; dec_c.regdest = 5'd0; end
                        default:   begin illegal = 1'b1; writer = 1'b0; dec_c.regdest = 5'd0; end
                    endcase
                end
                6'b001000: begin writer = 1'b1; dec_c.regdest = rt; dec_c.alusrc = 1'b1; end
                6'b001100: begin
                    writer = 1'b1; dec_c.regdest = rt; dec_c.alusrc = 1'b1;
                    dec_c.aluop = 4'd2; dec_c.imedext = {16'h0, instr[15:0]};
                end
                6'b001101: begin
                    writer = 1'b1; dec_c.regdest = rt; dec_c.alusrc = 1'b1;
                    dec_c.aluop = 4'd3; dec_c.imedext = {16'h0, instr[15:0]};
                end
                6'b001111: begin
                    writer = 1'b1; dec_c.regdest = rt; dec_c.alusrc = 1'b1;
                    dec_c.aluop = 4'd5; dec_c.imedext = {instr[15:0], 16'h0};
                end
                6'b100011: begin
                    writer = 1'b1; dec_c.regdest = rt; dec_c.alusrc = 1'b1; dec_c.memread = 1'b1;
                end
                6'b101011: begin dec_c.alusrc = 1'b1; dec_c.memwrite = 1'b1; end
                6'b000100: begin is_beq = 1'b1; dec_c.aluop = 4'd1; end
                6'b000101: begin is_bne = 1'b1; dec_c.aluop = 4'd1; end
                6'b000010: is_j = 1'b1;
                default:   illegal = 1'b1;
            endcase
        end
        dec_c.writereg = writer && (dec_c.regdest != 5'd0);
    end

    // Redirect decision; suppressed while stalled or on the squashed wrong-path slot
    always_comb begin
        take_c = 1'b0;
        type_c = 2'b00;
        if ((state_q == RUN) && !bus.ex_if_stall) begin
            if (illegal) begin
                take_c = 1'b1; type_c = 2'b11;
            end else if (is_j) begin
                take_c = 1'b1; type_c = 2'b10;
            end else if (is_jr) begin
                take_c = 1'b1; type_c = 2'b01;
            end else if ((is_beq && (opa == opb)) || (is_bne && (opa != opb))) begin
                take_c = 1'b1;
            end
        end
    end

    assign bus.id_if_selpcsource = take_c && !reset;
    assign bus.id_if_selpctype   = (take_c && !reset) ? type_c : 2'b00;
    assign bus.id_if_pcimd2ext   = reset ? 32'd0 : (illegal ? VECTOR_ADDR : br_target);
    assign bus.id_if_pcindex     = reset ? 32'd0 : (illegal ? VECTOR_ADDR : jmp_target);
    assign bus.id_if_rega        = reset ? 32'd0 : opa;

    // Next state and ID/EX load; stall holds both
    always_comb begin
        state_d = state_q;
        idex_d  = idex_q;
        if (!bus.ex_if_stall) begin
            state_d = take_c ? SQUASH : RUN;
            idex_d  = ((state_q == SQUASH) || illegal) ? '0 : dec_c;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            idex_q  <= '0;
        end else begin
            state_q <= state_d;
            idex_q  <= idex_d;
        end
    end

    assign bus.id_ex_instruc  = idex_q.instruc;
    assign bus.id_ex_nextpc   = idex_q.nextpc;
    assign bus.id_ex_rega     = idex_q.rega;
    assign bus.id_ex_regb     = idex_q.regb;
    assign bus.id_ex_imedext  = idex_q.imedext;
    assign bus.id_ex_regdest  = idex_q.regdest;
    assign bus.id_ex_writereg = idex_q.writereg;
    assign bus.id_ex_memread  = idex_q.memread;
    assign bus.id_ex_memwrite = idex_q.memwrite;
    assign bus.id_ex_alusrc   = idex_q.alusrc;
    assign bus.id_ex_aluop    = idex_q.aluop;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a table-driven reference model predicts the
// redirect (checked mid-cycle) and the ID/EX contents (checked after the edge).
module tb_decode_stage;
    localparam logic [31:0] VEC = 32'h0000_0040;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    decode_if bus ();
    decode_stage #(.VECTOR_ADDR(VEC)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct packed {
        logic        sel;
        logic [1:0]  typ;
        logic [31:0] pcimd;
        logic [31:0] pcindex;
        logic [31:0] rega;
        logic [4:0]  addra;
        logic [4:0]  addrb;
    } redir_t;

    typedef struct packed {
        logic [31:0] instruc;
        logic [31:0] nextpc;
        logic [31:0] rega;
        logic [31:0] regb;
        logic [31:0] imedext;
        logic [4:0]  regdest;
        logic [7:0]  ctrl;    // {writereg, memread, memwrite, alusrc, aluop}
    } idex_t;

    // Instruction table: dest 0 none / 1 rd / 2 rt; ext 0 sign / 1 zero / 2 lui;
    // br 0 none / 1 beq / 2 bne / 3 jr / 4 j
    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        bit         rtype;
        int         aluop;
        int         dest;
        int         ext;
        bit         src, mr, mw;
        int         br;
    } ent_t;

    ent_t   tbl[15];
    redir_t rq[$];
    idex_t  eq[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    bit     squash_m = 1'b0;
    idex_t  held_m   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [31:0] ins);
        for (int i = 0; i < 15; i++)
            if (ins[31:26] == tbl[i].op && (!tbl[i].rtype || ins[5:0] == tbl[i].funct)) return i;
        return -1;
    endfunction

    // Drive one ID slot and enqueue the predicted responses
    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input bit st,
                        input logic [31:0] da, input logic [31:0] db,
                        input bit wwe, input logic [4:0] wrd, input logic [31:0] wdata);
        redir_t r;
        idex_t  d;
        int     k, s;
        bit     ill, take;
        logic [31:0] a, b;
        logic signed [15:0] simm;
        @(posedge clock);
        #2;
        bus.if_id_instruc = ins;   bus.if_id_nextpc = pc;   bus.ex_if_stall = st;
        bus.reg_id_dataa = da;     bus.reg_id_datab = db;
        bus.wb_id_writereg = wwe;  bus.wb_id_regdest = wrd; bus.wb_id_writedata = wdata;
        a = da;
        b = db;
`ifdef ID_WB_BYPASS_EN
        if (wwe && wrd != 0 && wrd == ins[25:21]) a = wdata;
        if (wwe && wrd != 0 && wrd == ins[20:16]) b = wdata;
`endif
        k    = (ins == 0) ? -2 : lookup(ins);
        ill  = (k == -1);
        simm = ins[15:0];
        s    = simm;
        d = '0;
        d.instruc = ins; d.nextpc = pc; d.rega = a; d.regb = b; d.imedext = 32'(s);
        if (k >= 0) begin
            if (tbl[k].ext == 1) d.imedext = {16'h0, ins[15:0]};
            if (tbl[k].ext == 2) d.imedext = {ins[15:0], 16'h0};
            d.regdest = (tbl[k].dest == 1) ? ins[15:11] : (tbl[k].dest == 2) ? ins[20:16] : 5'd0;
            d.ctrl = {d.regdest != 0 && tbl[k].dest != 0, tbl[k].mr, tbl[k].mw, tbl[k].src,
                      4'(tbl[k].aluop)};
        end
        take = 1'b0;
        r.typ = 2'b00;
        if (!squash_m && !st) begin
            if (ill) begin take = 1; r.typ = 2'b11; end
            else if (k >= 0) begin
                if (tbl[k].br == 4) begin take = 1; r.typ = 2'b10; end
                if (tbl[k].br == 3) begin take = 1; r.typ = 2'b01; end
                if ((tbl[k].br == 1 && a == b) || (tbl[k].br == 2 && a != b)) take = 1;
            end
        end
        if (!take) r.typ = 2'b00;
        r.sel     = take;
        r.pcimd   = ill ? VEC : pc + 32'(s * 4);
        r.pcindex = ill ? VEC : {pc[31:28], ins[25:0], 2'b00};
        r.rega    = a;
        r.addra   = ins[25:21];
        r.addrb   = ins[20:16];
        rq.push_back(r);
        if (!st) begin
            held_m   = (squash_m || ill) ? idex_t'('0) : d;
            squash_m = take;
        end
        eq.push_back(held_m);
    endtask

    // Redirect monitor: combinational outputs sampled mid-cycle
    always @(negedge clock) begin
        redir_t r;
        if (rq.size() > 0) begin
            r = rq.pop_front();
            chk("selpcsource", 32'(bus.id_if_selpcsource), 32'(r.sel));
            chk("selpctype", 32'(bus.id_if_selpctype), 32'(r.typ));
            chk("pcimd2ext", bus.id_if_pcimd2ext, r.pcimd);
            chk("pcindex", bus.id_if_pcindex, r.pcindex);
            chk("id_if_rega", bus.id_if_rega, r.rega);
            chk("addra", 32'(bus.id_reg_addra), 32'(r.addra));
            chk("addrb", 32'(bus.id_reg_addrb), 32'(r.addrb));
        end
    end

    task automatic chk_idex(input string tag, input idex_t e);
        chk({tag, "instruc"}, bus.id_ex_instruc, e.instruc);
        chk({tag, "nextpc"}, bus.id_ex_nextpc, e.nextpc);
        chk({tag, "rega"}, bus.id_ex_rega, e.rega);
        chk({tag, "regb"}, bus.id_ex_regb, e.regb);
        chk({tag, "imedext"}, bus.id_ex_imedext, e.imedext);
        chk({tag, "regdest"}, 32'(bus.id_ex_regdest), 32'(e.regdest));
        chk({tag, "ctrl"}, 32'({bus.id_ex_writereg, bus.id_ex_memread, bus.id_ex_memwrite,
                                bus.id_ex_alusrc, bus.id_ex_aluop}), 32'(e.ctrl));
    endtask

    // ID/EX monitor: registered outputs sampled just after the edge
    always @(posedge clock) begin
        idex_t e;
        #1;
        if (eq.size() > 0) begin
            e = eq.pop_front();
            chk_idex("id_ex_", e);
        end
    end

    function automatic logic [31:0] rand_instr();
        int k;
        logic [4:0] rs, rt, rd;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0: return $urandom;
            1: return 32'h0;
            default: begin
                k = $urandom_range(0, 14);
                if (tbl[k].rtype) return {tbl[k].op, rs, rt, rd, 5'd0, tbl[k].funct};
                if (tbl[k].br == 4) return {tbl[k].op, 26'($urandom)};
                return {tbl[k].op, rs, rt, 16'($urandom)};
            end
        endcase
    endfunction

    initial begin
        tbl[0]  = '{6'd0,  6'd32, 1, 0, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{6'd0,  6'd34, 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{6'd0,  6'd36, 1, 2, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{6'd0,  6'd37, 1, 3, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{6'd0,  6'd42, 1, 4, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{6'd0,  6'd8,  1, 0, 0, 0, 0, 0, 0, 3};
        tbl[6]  = '{6'd8,  6'd0,  0, 0, 2, 0, 1, 0, 0, 0};
        tbl[7]  = '{6'd12, 6'd0,  0, 2, 2, 1, 1, 0, 0, 0};
        tbl[8]  = '{6'd13, 6'd0,  0, 3, 2, 1, 1, 0, 0, 0};
        tbl[9]  = '{6'd15, 6'd0,  0, 5, 2, 2, 1, 0, 0, 0};
        tbl[10] = '{6'd35, 6'd0,  0, 0, 2, 0, 1, 1, 0, 0};
        tbl[11] = '{6'd43, 6'd0,  0, 0, 0, 0, 1, 0, 1, 0};
        tbl[12] = '{6'd4,  6'd0,  0, 1, 0, 0, 0, 0, 0, 1};
        tbl[13] = '{6'd5,  6'd0,  0, 1, 0, 0, 0, 0, 0, 2};
        tbl[14] = '{6'd2,  6'd0,  0, 0, 0, 0, 0, 0, 0, 4};

        // Reset with a jump presented: redirect must stay quiet
        reset = 1'b1;
        bus.ex_if_stall = 0; bus.if_id_nextpc = 32'h3000_0010; bus.if_id_instruc = 32'h0800_0040;
        bus.reg_id_dataa = 0; bus.reg_id_datab = 0;
        bus.wb_id_writereg = 0; bus.wb_id_regdest = 0; bus.wb_id_writedata = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_selpcsource", 32'(bus.id_if_selpcsource), 32'd0);
        chk("rst_selpctype", 32'(bus.id_if_selpctype), 32'd0);
        chk_idex("rst_", '0);
        bus.if_id_instruc = 32'h0; bus.if_id_nextpc = 32'h0;
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;
        chk_idex("post_rst_", '0);
        chk("post_rst_sel", 32'(bus.id_if_selpcsource), 32'd0);

        // Directed cases
        step(32'h2022_FFFC, 32'h100, 0, 32'd9, 32'd1, 0, 0, 0);              // addi r2,r1,-4
        step(32'h1022_0003, 32'h200, 0, 32'd5, 32'd5, 0, 0, 0);              // beq taken
        step(32'h8C43_0000, 32'h204, 0, 32'd1, 32'd2, 0, 0, 0);              // squashed lw
        step(32'h0800_0040, 32'h3000_0010, 1, 32'd0, 32'd0, 0, 0, 0);        // j under stall
        step(32'h0800_0040, 32'h3000_0010, 0, 32'd0, 32'd0, 0, 0, 0);        // j
        step(32'h0000_0000, 32'h3000_0014, 0, 32'd0, 32'd0, 0, 0, 0);        // squashed nop
        step(32'hFC00_0000, 32'h400, 0, 32'd3, 32'd4, 0, 0, 0);              // illegal opcode
        step(32'h0000_0000, 32'h404, 0, 32'd0, 32'd0, 0, 0, 0);              // squashed slot
        step(32'h1460_0000, 32'h500, 0, 32'd0, 32'd0, 1, 5'd3, 32'd7);       // bne r3,r0 + WB r3
        step(32'h0000_0000, 32'h504, 0, 32'd0, 32'd0, 0, 0, 0);
        step(32'h3C05_ABCD, 32'h600, 0, 32'd0, 32'd0, 0, 0, 0);              // lui
        step(32'h3406_8001, 32'h604, 0, 32'd0, 32'd0, 0, 0, 0);              // ori zero-ext
        step(32'h2000_0005, 32'h608, 0, 32'd0, 32'd0, 0, 0, 0);              // addi to r0

        // Reset asserted while a squash is pending
        step(32'h1022_0003, 32'h700, 0, 32'd5, 32'd5, 0, 0, 0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        bus.if_id_instruc = 32'h0;
        #1;
        chk_idex("mid_rst_", '0);
        chk("mid_rst_sel", 32'(bus.id_if_selpcsource), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        squash_m = 1'b0;
        held_m = '0;
        step(32'h8C43_0010, 32'h800, 0, 32'd11, 32'd12, 0, 0, 0);            // must not be squashed

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] da, db;
            da = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
            db = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
            step(rand_instr(), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) == 0, da, db,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clock);
        #2;
        n_tests++;
        if (rq.size() != 0 || eq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", rq.size(), eq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
